// File: rtl/ids_bus_pkg.sv
// ----------------------------------------------------------------------------
// ids_bus_pkg
// Shared definitions for the IDS bus arbiter: requester indices, the arbiter
// state encoding and the width of the optional burst hold counter.
// Optional feature macro used by the arbiter: IDS_ARB_BURST_LIMIT_EN.
// ----------------------------------------------------------------------------
package ids_bus_pkg;

    // Requester slots on the shared IDS bus.
    localparam int REQ_SPI  = 0;
    localparam int REQ_DMEM = 1;
    localparam int REQ_DMA  = 2;

    // Width of the burst hold counter (MAX_BURST is limited to 2..255).
    localparam int HOLD_CNT_W = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

endpackage : ids_bus_pkg

// File: rtl/ids_bus_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// ids_rr_pick
// Combinational round-robin picker. Scans the request vector starting at
// last+1, wrapping around, and returns the first requester that is not masked
// by the exclude vector.
//
// Ports:
//   req     in   NUM_REQ  request vector
//   last    in   ID_W     index of the most recent winner
//   exclude in   NUM_REQ  requesters that may not win this scan
//   winner  out  ID_W     index of the selected requester (0 when none)
//   found   out  1        a winner exists
// ----------------------------------------------------------------------------
module ids_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    input  logic [NUM_REQ-1:0] exclude,
    output logic [ID_W-1:0]    winner,
    output logic               found
);

    int              idx;
    logic [ID_W-1:0] idx_w;

    always_comb begin
        // NOTE: every output and temporary gets a default first so no latch is inferred.
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        idx_w  = '0;
        // Offsets 1..NUM_REQ visit every slot once, ending on 'last' itself.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = ID_W'(idx);
            if (!found && req[idx_w] && !exclude[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
    end

endmodule : ids_rr_pick

// File: rtl/ids_bus_arbiter.sv
// ----------------------------------------------------------------------------
// ids_bus_arbiter
// Round-robin arbiter for the shared IDS bus (SPI slave, RV DMEM, DMA).
// The holder keeps the grant while it requests; on release the next
// requester is granted on the following edge with no idle gap. Grants are
// registered and always one-hot (or zero).
//
// Optional feature: define IDS_ARB_BURST_LIMIT_EN to enable burst-limit
// preemption. A holder that has held the grant for MAX_BURST cycles is
// preempted when another requester is pending and its i_lock bit is low.
// Without the macro i_lock is ignored.
//
// Ports:
//   i_clk        in   1        clock, rising edge
//   i_rst        in   1        synchronous active-high reset
//   i_req        in   NUM_REQ  per-requester request level
//   i_lock       in   NUM_REQ  per-requester lock (burst-limit build only)
//   o_gnt        out  NUM_REQ  one-hot grant, registered
//   o_gnt_valid  out  1        any grant held, registered
//   o_gnt_id     out  ID_W     index of the holder, 0 when no grant
//   o_busy       out  1        request pending or grant held
// ----------------------------------------------------------------------------
module ids_bus_arbiter
    import ids_bus_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 16,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_lock,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_gnt_valid,
    output logic [ID_W-1:0]    o_gnt_id,
    output logic               o_busy
);

    localparam logic [HOLD_CNT_W-1:0] CNT_MAX = HOLD_CNT_W'(MAX_BURST - 1);
    localparam logic [NUM_REQ-1:0]    ONE_HOT = NUM_REQ'(1);

    arb_state_t      state;
    logic [ID_W-1:0] last;

    logic [ID_W-1:0] winner;
    logic            found;
    logic            holder_req;
    logic            preempt;
    logic            load_grant;
    logic            release_bus;

    // The current holder is excluded from the scan. In IDLE o_gnt is zero so
    // nothing is excluded; on a release the holder no longer requests anyway,
    // so the exclusion only matters for burst preemption.
    ids_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (i_req),
        .last    (last),
        .exclude (o_gnt),
        .winner  (winner),
        .found   (found)
    );

    assign holder_req = i_req[o_gnt_id];

`ifdef IDS_ARB_BURST_LIMIT_EN
    logic [HOLD_CNT_W-1:0] hold_cnt;

    // found already excludes the holder, so it means "another requester waits".
    assign preempt = (state == ARB_GRANT) && holder_req && (hold_cnt == CNT_MAX)
                   && found && !i_lock[o_gnt_id];
`else
    logic unused_cfg;

    assign preempt    = 1'b0;
    assign unused_cfg = ^{i_lock, CNT_MAX};
`endif

    // A new grant is loaded from IDLE, on a holder release with others
    // waiting, or on preemption. The bus goes idle only when nobody is left.
    assign load_grant  = found && ((state == ARB_IDLE) || !holder_req || preempt);
    assign release_bus = (state == ARB_GRANT) && !holder_req && !found;

    always_ff @(posedge i_clk) begin
        // NOTE: all sequential state uses non-blocking assignments.
        if (i_rst) begin
            state       <= ARB_IDLE;
            last        <= ID_W'(NUM_REQ - 1);
            o_gnt       <= '0;
            o_gnt_valid <= 1'b0;
            o_gnt_id    <= '0;
        end else if (load_grant) begin
            state       <= ARB_GRANT;
            last        <= winner;
            o_gnt       <= ONE_HOT << winner;
            o_gnt_valid <= 1'b1;
            o_gnt_id    <= winner;
        end else if (release_bus) begin
            state       <= ARB_IDLE;
            o_gnt       <= '0;
            o_gnt_valid <= 1'b0;
            o_gnt_id    <= '0;
        end
    end

`ifdef IDS_ARB_BURST_LIMIT_EN
    // Clears on every new grant, counts each cycle the grant is held and
    // saturates at MAX_BURST-1 while locked or while nobody else waits.
    always_ff @(posedge i_clk) begin
        if (i_rst || load_grant) begin
            hold_cnt <= '0;
        end else if ((state == ARB_GRANT) && (hold_cnt != CNT_MAX)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`endif

    assign o_busy = (|i_req) | o_gnt_valid;

endmodule : ids_bus_arbiter

// File: tb/tb_ids_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ids_bus_arbiter
// Scoreboard bench for ids_bus_arbiter. The driver applies inputs, advances a
// behavioural model of the grant rules and queues the expected outputs; a
// monitor pops one entry per cycle and compares it with the DUT.
// Honours IDS_ARB_BURST_LIMIT_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_ids_bus_arbiter;
    import ids_bus_pkg::*;

    localparam int N   = 3;
    localparam int MB  = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   lock = '0;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           busy;

    always #5 clk = ~clk;

    ids_bus_arbiter #(
        .NUM_REQ   (N),
        .MAX_BURST (MB),
        .ID_W      (IDW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_lock      (lock),
        .o_gnt       (gnt),
        .o_gnt_valid (gnt_valid),
        .o_gnt_id    (gnt_id),
        .o_busy      (busy)
    );

    typedef struct {
        logic [N-1:0]   gnt;
        logic           valid;
        logic [IDW-1:0] id;
        logic           busy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: holder index (-1 = none), last winner, cycles held.
    int m_holder = -1;
    int m_last   = N - 1;
    int m_cnt    = 0;
    int m_age    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int m_pick(input logic [N-1:0] r, input int excl);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic m_take(input int w);
        m_holder = w;
        if (w >= 0) begin
            m_last = w;
            m_cnt  = 0;
            m_age  = 0;
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rs);
        int  w;
        bit  pre;
        pre = 1'b0;
        if (rs) begin
            m_holder = -1;
            m_last   = N - 1;
            m_cnt    = 0;
            m_age    = 0;
        end else if (m_holder < 0) begin
            m_take(m_pick(r, -1));
        end else begin
            w = m_pick(r, m_holder);
`ifdef IDS_ARB_BURST_LIMIT_EN
            pre = r[m_holder] && (m_cnt == MB - 1) && !l[m_holder] && (w >= 0);
`else
            if (l != l) pre = 1'b1;
`endif
            if (!r[m_holder] || pre) begin
                m_take(w);
            end else begin
                m_age++;
                if (m_cnt < MB - 1) m_cnt++;
            end
        end
    endtask

    // Apply inputs for one cycle, queue the outputs expected after the edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rs);
        exp_t e;
        req  = r;
        lock = l;
        rst  = rs;
        model_step(r, l, rs);
        e.valid = (m_holder >= 0);
        e.gnt   = e.valid ? (N'(1) << m_holder) : '0;
        e.id    = e.valid ? IDW'(m_holder) : '0;
        e.busy  = (|r) | e.valid;
        sb.push_back(e);
        @(posedge clk);
        #3;
    endtask

    // Monitor: outputs sampled 2 time units after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("o_gnt",       32'(gnt),       32'(e.gnt));
                check("o_gnt_valid", 32'(gnt_valid), 32'(e.valid));
                check("o_gnt_id",    32'(gnt_id),    32'(e.id));
                check("o_busy",      32'(busy),      32'(e.busy));
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] l;
        @(posedge clk);
        #3;

        // Reset.
        step(3'b000, 3'b000, 1'b1);
        step(3'b000, 3'b000, 1'b1);
        step(3'b000, 3'b000, 1'b0);

        // All three requesting; each holder releases after holding a while.
        for (int i = 0; i < 15; i++) begin
            r = 3'b111;
            if (m_holder >= 0 && m_age >= 1) r[m_holder] = 1'b0;
            step(r, 3'b000, 1'b0);
        end
        step(3'b000, 3'b000, 1'b0);

        // Single DMA requester for 5 cycles.
        step(3'b000, 3'b000, 1'b1);
        for (int i = 0; i < 5; i++) step(3'b100, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b0);

        // SPI granted, then DMEM and DMA together: DMEM first, DMA on release.
        step(3'b001, 3'b000, 1'b0);
        step(3'b001, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b0);
        step(3'b110, 3'b000, 1'b0);
        step(3'b110, 3'b000, 1'b0);
        step(3'b100, 3'b000, 1'b0);
        step(3'b100, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b0);

        // Burst limit: DMA holds, SPI joins; then the same with DMA locked.
        step(3'b100, 3'b000, 1'b0);
        step(3'b100, 3'b000, 1'b0);
        for (int i = 0; i < 6; i++) step(3'b101, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b0);
        step(3'b100, 3'b100, 1'b0);
        step(3'b100, 3'b100, 1'b0);
        for (int i = 0; i < 7; i++) step(3'b101, 3'b100, 1'b0);
        for (int i = 0; i < 3; i++) step(3'b101, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b0);

        // Reset during a DMEM grant, then all request: SPI wins first.
        step(3'b010, 3'b000, 1'b0);
        step(3'b010, 3'b000, 1'b0);
        step(3'b010, 3'b000, 1'b1);
        for (int i = 0; i < 4; i++) step(3'b111, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b0);

        // DMEM drops its pending request as SPI releases: DMA next, or idle.
        step(3'b001, 3'b000, 1'b1);
        step(3'b001, 3'b000, 1'b0);
        step(3'b111, 3'b000, 1'b0);
        step(3'b100, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b0);
        step(3'b001, 3'b000, 1'b1);
        step(3'b001, 3'b000, 1'b0);
        step(3'b011, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            r = 3'($urandom_range(0, 7));
            l = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            step(r, l, ($urandom_range(0, 63) == 0));
        end
        step(3'b000, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ids_bus_arbiter
